// File: rtl/mmio_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mmio_pkg : register offsets, UART FSM encoding, status bit map. rev 1.0
// ----------------------------------------------------------------------
package mmio_pkg;

  localparam logic [31:0] UART_TXDATA = 32'd0;
  localparam logic [31:0] UART_STATUS = 32'd4;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t UART_IDLE  = 2'd0;
  localparam uart_state_t UART_START = 2'd1;
  localparam uart_state_t UART_DATA  = 2'd2;
  localparam uart_state_t UART_STOP  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// sync_fifo : show-ahead synchronous FIFO, wrap-bit pointers. rev 1.0
// ----------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Full/empty gate here so callers may present requests unconditionally.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------
// mmio_uart_tx : MMIO 8N1 UART transmitter with TX byte FIFO. rev 1.0
// ----------------------------------------------------------------------
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'hf0000100,
  parameter int          DIV        = 868,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oe,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        txd,
  output logic        busy
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic          is_write;
  logic          hit_data;
  logic          hit_status;
  logic          wr_data;
  logic          rd_data;
  logic          rd_status;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_n;
  logic [7:0]    fifo_dout;
  logic          pop;

  logic          ovf;
  logic [8:0]    count_ext;
  logic [31:0]   status_word;

  uart_state_t   state;
  uart_state_t   state_n;
  logic [15:0]   cnt;
  logic [15:0]   cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;

  logic          unused_bits;

  assign is_write   = |we;
  assign hit_data   = oe && (addr == BASE + UART_TXDATA);
  assign hit_status = oe && (addr == BASE + UART_STATUS);
  assign wr_data    = hit_data && is_write;
  assign rd_data    = hit_data && !is_write;
  assign rd_status  = hit_status && !is_write;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_data),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign count_ext   = 9'(fifo_count);
  assign unused_bits = &{1'b0, wdata[31:8], count_ext[8]};

  always_comb begin
    status_word                         = '0;
    status_word[ST_EMPTY]               = fifo_empty;
    status_word[ST_FULL]                = fifo_full;
    status_word[ST_BUSY]                = busy;
    status_word[ST_OVF]                 = ovf;
    status_word[ST_COUNT_LSB +: 8]      = count_ext[7:0];
  end

  // Occupancy after this edge, so busy can be registered without lag.
  assign count_n = fifo_count + CW'(wr_data && !fifo_full) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= rd_data || rd_status;
      if (rd_status)
        rdata <= status_word;
      else if (rd_data)
        rdata <= {31'b0, !fifo_full};
      else
        rdata <= '0;
      // An overflow in the clearing cycle wins over the read-to-clear.
      ovf   <= (ovf && !rd_status) || (wr_data && fifo_full);
      busy  <= (state_n != UART_IDLE) || (count_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= UART_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = DIV_M1;
          state_n = UART_START;
        end
      end
      UART_START: begin
        if (cnt == '0) begin
          cnt_n   = DIV_M1;
          idx_n   = '0;
          state_n = UART_DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      UART_DATA: begin
        if (cnt == '0) begin
          cnt_n   = DIV_M1;
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = UART_STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      UART_STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            cnt_n   = DIV_M1;
            state_n = UART_START;
          end else begin
            cnt_n   = '0;
            state_n = UART_IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      UART_START: txd = 1'b0;
      UART_DATA:  txd = shift[0];
      default:    txd = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor data bus. It decodes the TX-data and status words in the `0xf` MMIO region and buffers written bytes in a small FIFO. Bytes are serialized as 8N1 frames on `txd`. It replaces the testbench-only character output with a synthesizable peripheral, and shares the `mem_*` bus with the data RAM and the halt register.

## Interface
Parameters:
- `BASE`, `32'hf0000100`: address of the TX-data word; the status word is at `BASE+4`.
- `DIV`, `868`: clocks per bit (100 MHz / 115200). Legal range 2..65535.
- `DEPTH_LOG2`, `4`: FIFO depth is 2**DEPTH_LOG2 bytes. Legal range 1..8.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `oe`  in  1  bus request valid, one cycle per request.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data; only bits [7:0] are used.
- `we`  in  4  byte write enables. Any set bit marks a write; all zero marks a read.
- `rdata`  out  32  read data, valid while `ready` is high.
- `ready`  out  1  read response strobe.
- `txd`  out  1  serial output, idles high.
- `busy`  out  1  high while a frame is shifting or the FIFO is non-empty.

## Operation
- **Address decode.** A request is selected when `oe` is high and `addr == BASE` or `addr == BASE+4`. Unselected requests are ignored entirely.
- **Write to `BASE`.** Pushes `wdata[7:0]`. If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Fullness is evaluated before any same-cycle pop, so a write is dropped when full even if a pop happens that cycle.
- **Write to `BASE+4`.** No effect.
- **Writes are posted.** A write never produces `ready`.
- **Read of `BASE`.** Returns `32'd1` if the FIFO is not full, else `32'd0`. This is the "TX available" polling word.
- **Read of `BASE+4`.** Returns `{16'b0, count[7:0], 4'b0, ovf, busy, full, empty}`, where `count` is zero-extended FIFO occupancy.
  - The read clears `ovf` one cycle later.
  - If an overflow occurs in the same cycle as the read, `ovf` stays set.
- **Transmit FSM states:** IDLE, START, DATA, STOP.
- **IDLE.**
  - `txd=1`.
  - If the FIFO is non-empty: pop into the shift register, go to START, load the bit counter with DIV-1.
- **Bit timing.** Each of START, DATA and STOP lasts exactly DIV cycles, counted down from DIV-1 to 0; advance on 0.
- **START.** `txd=0`.
- **DATA.** `txd=shift[0]`. Shift right at the end of each bit, 8 bits LSB first; a 3-bit index wraps 7→0 on exit.
- **STOP.** `txd=1`. At the end of the bit:
  - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
  - FIFO empty: go to IDLE.
- **Frame length** is exactly 10*DIV cycles.

## Timing
- **Reset** (rst low at a clk edge) applies:
  - Outputs: `txd=1`, `ready=0`, `rdata=0`, `busy=0`.
  - State: FIFO empty, `ovf=0`, FSM IDLE, counters 0.
  - Reset mid-frame truncates the frame immediately; `txd` returns high at that edge.
- **Read latency.** A read sampled at edge e0 drives `ready=1` with `rdata` during the cycle after e0, for exactly one cycle. `ready` is registered.
- **Push timing.** A write sampled at e0 updates the FIFO at e0.
- **Start of transmission.** With the FSM idle, the pop occurs at e1 and `txd` falls at e1. First-byte latency from the write edge is 1 cycle.
- **FIFO ports.** Push and pop in the same cycle are both honoured when the FIFO is neither full nor empty; `count` is unchanged.
- **`busy`** is registered and reflects the state after each edge.

## Structure
- **Package `mmio_pkg`:**
  - register offsets `UART_TXDATA=0`, `UART_STATUS=4`;
  - state encoding `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`;
  - status bit positions.
- **Sub-module `sync_fifo`:**
  - parameters WIDTH and DEPTH_LOG2;
  - push/pop/full/empty/count ports;
  - pointers carry one extra wrap bit.
- **Top of `mmio_uart_tx`:** decode, response register, FSM, baud counter.

## Test plan
- **Basic frame.** DIV=4: write `0x55` to BASE.
  - `txd` is low from e1 for 4 cycles, then reads 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - `busy` falls 40 cycles after e1.
- **Back-to-back.** DIV=4: write `0x00` then `0xFF` on consecutive cycles.
  - The second start bit begins exactly 40 cycles after the first, with no idle gap.
- **Overflow.** DEPTH_LOG2=2, DIV=100: perform 6 writes.
  - The first byte is popped immediately and 4 bytes are queued; the 6th write is dropped.
  - Status read returns full=1, ovf=1, count=4. A second status read returns ovf=0.
  - Read of BASE returns 0 while full and 1 after one frame completes.
- **Decode and latency.**
  - Read of BASE while empty: `ready` is high one cycle later with `rdata=1`.
  - Read of `BASE+8`: no `ready`.
  - Write to BASE: no `ready`.
- **Reset mid-frame.** Assert rst low during DATA bit 3.
  - `txd=1`, status reads empty=1, count=0.
  - A subsequent write transmits normally.
